// File: rtl/ecdsa_verify_sequencer_pkg.sv
// Shared types for the ECDSA verify subsystem: result codes and the
// verify sequencer state encoding.
package elliptic_curve_structs;

  typedef enum logic [1:0] {
    ERR_NONE           = 2'd0,
    ERR_HASH_TIMEOUT   = 2'd1,
    ERR_VERIFY_TIMEOUT = 2'd2,
    ERR_ABORTED        = 2'd3   // also reports a dropped (overrun) request
  } verify_err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HASH_START,
    ST_WAIT_HASH,
    ST_VERIFY_START,
    ST_WAIT_VERIFY,
    ST_REPORT
  } verify_seq_state_t;

endpackage

// File: rtl/ecdsa_verify_sequencer_phase_watchdog.sv
// Saturating phase watchdog shared by the hash and verify wait phases;
// expired flags the last allowed cycle (count == limit-1) while enabled.
module phase_watchdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = enable && (count == (limit - TIMEOUT_W'(1)));

endmodule

// File: rtl/ecdsa_verify_sequencer.sv
// ECDSA verify sequencer: runs the hash core then the verify datapath, with
// phase timeouts, bounded hash retry, abort, a one-deep request latch and a held report.
module ecdsa_verify_sequencer
  import elliptic_curve_structs::*;
#(
  parameter int TIMEOUT_W      = 16,
  parameter int HASH_TIMEOUT   = 1024,
  parameter int VERIFY_TIMEOUT = 60000,
  parameter int MAX_RETRY      = 2,
  parameter int QUEUE_EN       = 1,
  localparam int RETRY_W       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init_verify,
  input  logic               abort,
  input  logic               done_hash,
  input  logic               done_verify,
  input  logic               sig_ok,
  output logic               start_hash,
  output logic               load_hash,
  output logic               start_verify,
  output logic               busy,
  output logic               result_valid,
  output logic               result_ok,
  output logic [1:0]         err_code,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               pending
);

  localparam logic [TIMEOUT_W-1:0] HASH_LIMIT   = TIMEOUT_W'(HASH_TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] VERIFY_LIMIT = TIMEOUT_W'(VERIFY_TIMEOUT);
  localparam logic [RETRY_W-1:0]   RETRY_MAX    = RETRY_W'(MAX_RETRY);

  verify_seq_state_t    state, state_next;
  verify_err_t          err_q, report_err;
  logic                 report_load, report_ok;
  logic                 retry_inc, retry_clear, op_start;
  logic                 pending_set, pending_clr, drop, overrun;
  logic                 wd_clear, wd_enable, wd_expired;
  logic [TIMEOUT_W-1:0] wd_limit;

  assign busy     = (state != ST_IDLE);
  assign err_code = err_q;
  assign wd_limit = (state == ST_WAIT_VERIFY) ? VERIFY_LIMIT : HASH_LIMIT;

  // A busy request is latched once; with the latch full (or disabled) it is dropped.
  always_comb begin
    pending_set = 1'b0;
    drop        = 1'b0;
    if (init_verify && busy) begin
      if ((QUEUE_EN != 0) && !pending) pending_set = 1'b1;
      else                             drop        = 1'b1;
    end
  end

  phase_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (wd_limit),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    start_hash   = 1'b0;
    load_hash    = 1'b0;
    start_verify = 1'b0;
    result_valid = 1'b0;
    wd_clear     = 1'b0;
    wd_enable    = 1'b0;
    retry_inc    = 1'b0;
    retry_clear  = 1'b0;
    op_start     = 1'b0;
    pending_clr  = 1'b0;
    report_load  = 1'b0;
    report_err   = ERR_NONE;
    report_ok    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        retry_clear = 1'b1;
        if (init_verify || pending) begin
          state_next  = ST_HASH_START;
          op_start    = 1'b1;
          // A fresh request arriving alongside the queued one takes its slot.
          pending_clr = pending && !init_verify;
        end
      end
      ST_HASH_START: begin
        start_hash = 1'b1;
        wd_clear   = 1'b1;
        if (abort) begin
          state_next  = ST_REPORT;
          report_load = 1'b1;
          report_err  = ERR_ABORTED;
        end else begin
          state_next = ST_WAIT_HASH;
        end
      end
      ST_WAIT_HASH: begin
        wd_enable = 1'b1;
        if (abort) begin
          state_next  = ST_REPORT;
          report_load = 1'b1;
          report_err  = ERR_ABORTED;
        end else if (done_hash) begin
          load_hash  = 1'b1;
          state_next = ST_VERIFY_START;
        end else if (wd_expired) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_inc  = 1'b1;
            state_next = ST_HASH_START;
          end else begin
            state_next  = ST_REPORT;
            report_load = 1'b1;
            report_err  = ERR_HASH_TIMEOUT;
          end
        end
      end
      ST_VERIFY_START: begin
        start_verify = 1'b1;
        wd_clear     = 1'b1;
        if (abort) begin
          state_next  = ST_REPORT;
          report_load = 1'b1;
          report_err  = ERR_ABORTED;
        end else begin
          state_next = ST_WAIT_VERIFY;
        end
      end
      ST_WAIT_VERIFY: begin
        wd_enable = 1'b1;
        if (abort) begin
          state_next  = ST_REPORT;
          report_load = 1'b1;
          report_err  = ERR_ABORTED;
        end else if (done_verify) begin
          state_next  = ST_REPORT;
          report_load = 1'b1;
          report_ok   = sig_ok;
        end else if (wd_expired) begin
          state_next  = ST_REPORT;
          report_load = 1'b1;
          report_err  = ERR_VERIFY_TIMEOUT;
        end
      end
      ST_REPORT: begin
        result_valid = 1'b1;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      overrun   <= 1'b0;
      retry_cnt <= '0;
      err_q     <= ERR_NONE;
      result_ok <= 1'b0;
    end else begin
      if (pending_set)      pending <= 1'b1;
      else if (pending_clr) pending <= 1'b0;

      if (retry_clear)    retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + RETRY_W'(1);

      if (op_start)  overrun <= 1'b0;
      else if (drop) overrun <= 1'b1;

      // A dropped request during the operation turns its report into an error.
      if (report_load) begin
        err_q     <= (overrun || drop) ? ERR_ABORTED : report_err;
        result_ok <= report_ok && !(overrun || drop);
      end else if (drop) begin
        err_q <= ERR_ABORTED;
      end
    end
  end

endmodule

// File: tb/tb_ecdsa_verify_sequencer.sv
// Scoreboard bench for ecdsa_verify_sequencer: three configurations share one
// stimulus bus, expected pulses are queued with their cycle and a monitor pops them.
module tb_ecdsa_verify_sequencer;

  localparam int EV_NONE = 0;
  localparam int EV_SH   = 1;   // start_hash
  localparam int EV_LH   = 2;   // load_hash
  localparam int EV_SV   = 3;   // start_verify
  localparam int EV_RES  = 4;   // result_valid

  typedef struct {
    int kind;
    int cyc;
    int ok;
    int err;
    int retry;
  } exp_t;

  logic clk;
  logic reset;
  logic init_verify, abort, done_hash, done_verify, sig_ok;
  logic [1:0] sel;

  logic [2:0] g_init, g_abort, g_dh, g_dv;
  logic [2:0] o_sh, o_lh, o_sv, o_busy, o_rv, o_ok, o_pend;
  logic [2:0][1:0] o_err, o_retry;

  logic       m_sh, m_lh, m_sv, m_busy, m_rv, m_ok, m_pend;
  logic [1:0] m_err, m_retry;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Only the selected configuration sees requests; the others stay idle.
  assign g_init  = {3{init_verify}} & (3'b001 << sel);
  assign g_abort = {3{abort}}       & (3'b001 << sel);
  assign g_dh    = {3{done_hash}}   & (3'b001 << sel);
  assign g_dv    = {3{done_verify}} & (3'b001 << sel);

  assign m_sh    = o_sh[sel];
  assign m_lh    = o_lh[sel];
  assign m_sv    = o_sv[sel];
  assign m_busy  = o_busy[sel];
  assign m_rv    = o_rv[sel];
  assign m_ok    = o_ok[sel];
  assign m_pend  = o_pend[sel];
  assign m_err   = o_err[sel];
  assign m_retry = o_retry[sel];

  // Default timing, queue enabled.
  ecdsa_verify_sequencer u_dut_nom (
    .clk(clk), .reset(reset), .init_verify(g_init[0]), .abort(g_abort[0]),
    .done_hash(g_dh[0]), .done_verify(g_dv[0]), .sig_ok(sig_ok),
    .start_hash(o_sh[0]), .load_hash(o_lh[0]), .start_verify(o_sv[0]),
    .busy(o_busy[0]), .result_valid(o_rv[0]), .result_ok(o_ok[0]),
    .err_code(o_err[0]), .retry_cnt(o_retry[0]), .pending(o_pend[0])
  );

  // Short timeouts, queue enabled.
  ecdsa_verify_sequencer #(
    .HASH_TIMEOUT(8), .VERIFY_TIMEOUT(16), .MAX_RETRY(2), .QUEUE_EN(1)
  ) u_dut_short (
    .clk(clk), .reset(reset), .init_verify(g_init[1]), .abort(g_abort[1]),
    .done_hash(g_dh[1]), .done_verify(g_dv[1]), .sig_ok(sig_ok),
    .start_hash(o_sh[1]), .load_hash(o_lh[1]), .start_verify(o_sv[1]),
    .busy(o_busy[1]), .result_valid(o_rv[1]), .result_ok(o_ok[1]),
    .err_code(o_err[1]), .retry_cnt(o_retry[1]), .pending(o_pend[1])
  );

  // Short timeouts, queue disabled.
  ecdsa_verify_sequencer #(
    .HASH_TIMEOUT(8), .VERIFY_TIMEOUT(16), .MAX_RETRY(2), .QUEUE_EN(0)
  ) u_dut_noq (
    .clk(clk), .reset(reset), .init_verify(g_init[2]), .abort(g_abort[2]),
    .done_hash(g_dh[2]), .done_verify(g_dv[2]), .sig_ok(sig_ok),
    .start_hash(o_sh[2]), .load_hash(o_lh[2]), .start_verify(o_sv[2]),
    .busy(o_busy[2]), .result_valid(o_rv[2]), .result_ok(o_ok[2]),
    .err_code(o_err[2]), .retry_cnt(o_retry[2]), .pending(o_pend[2])
  );

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, actual, expected);
  endtask

  task automatic push_exp(input int kind, input int c, input int ok = 0,
                          input int err = 0, input int retry = 0);
    exp_t e;
    e.kind  = kind;
    e.cyc   = c;
    e.ok    = ok;
    e.err   = err;
    e.retry = retry;
    exp_q.push_back(e);
  endtask

  // Returns 1ns after the posedge that starts cycle k; inputs set here are sampled at k+1.
  task automatic at_cycle(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_init(input int k);
    at_cycle(k);
    init_verify = 1'b1;
    at_cycle(k + 1);
    init_verify = 1'b0;
  endtask

  task automatic drive_dh(input int k);
    at_cycle(k);
    done_hash = 1'b1;
    at_cycle(k + 1);
    done_hash = 1'b0;
  endtask

  task automatic drive_dv(input int k, input logic ok);
    at_cycle(k);
    sig_ok      = ok;
    done_verify = 1'b1;
    at_cycle(k + 1);
    done_verify = 1'b0;
  endtask

  task automatic drive_abort(input int k);
    at_cycle(k);
    abort = 1'b1;
    at_cycle(k + 1);
    abort = 1'b0;
  endtask

  task automatic check_levels(input string tag, input int busy_e, input int pend_e,
                              input int err_e, input int ok_e, input int retry_e);
    check({tag, "_busy"},    int'(m_busy),  busy_e);
    check({tag, "_pending"}, int'(m_pend),  pend_e);
    check({tag, "_err"},     int'(m_err),   err_e);
    check({tag, "_ok"},      int'(m_ok),    ok_e);
    check({tag, "_retry"},   int'(m_retry), retry_e);
  endtask

  always @(negedge clk) begin : monitor
    int   kind;
    exp_t e;
    kind = EV_NONE;
    if (m_sh === 1'b1)      kind = EV_SH;
    else if (m_lh === 1'b1) kind = EV_LH;
    else if (m_sv === 1'b1) kind = EV_SV;
    else if (m_rv === 1'b1) kind = EV_RES;
    if (kind != EV_NONE) begin
      if (exp_q.size() == 0) begin
        check("spurious_event", kind, EV_NONE);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (e.kind == EV_RES) begin
          check("result_ok", int'(m_ok), e.ok);
          check("err_code", int'(m_err), e.err);
          check("retry_cnt", int'(m_retry), e.retry);
        end
      end
    end
  end

  initial begin
    init_verify = 1'b0;
    abort       = 1'b0;
    done_hash   = 1'b0;
    done_verify = 1'b0;
    sig_ok      = 1'b0;
    reset       = 1'b1;
    sel         = 2'd0;

    at_cycle(2);
    check_levels("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Nominal pass, default timing.
    push_exp(EV_SH, 6);
    push_exp(EV_LH, 16);
    push_exp(EV_SV, 17);
    push_exp(EV_RES, 38, 1, 0, 0);
    drive_init(5);
    drive_dh(16);
    drive_dv(37, 1'b1);
    at_cycle(39);
    check_levels("nominal_idle", 0, 0, 0, 1, 0);

    // Queueing: one request latched, a second dropped and reported as error 3.
    push_exp(EV_SH, 46);
    push_exp(EV_LH, 51);
    push_exp(EV_SV, 52);
    push_exp(EV_RES, 56, 0, 3, 0);
    push_exp(EV_SH, 58);
    push_exp(EV_LH, 60);
    push_exp(EV_SV, 61);
    push_exp(EV_RES, 64, 1, 0, 0);
    drive_init(45);
    drive_init(48);
    check("queue_pending_set", int'(m_pend), 1);
    drive_init(50);
    drive_dh(51);
    drive_dv(55, 1'b1);
    at_cycle(57);
    check_levels("queue_idle", 0, 1, 3, 0, 0);
    at_cycle(58);
    check_levels("queue_restart", 1, 0, 3, 0, 0);
    drive_dh(60);
    drive_dv(63, 1'b1);
    at_cycle(66);
    check_levels("queue_done", 0, 0, 0, 1, 0);
    sel = 2'd1;

    // Hash retry: first attempt times out, second completes.
    push_exp(EV_SH, 71);
    push_exp(EV_SH, 80);
    push_exp(EV_LH, 83);
    push_exp(EV_SV, 84);
    push_exp(EV_RES, 87, 1, 0, 1);
    drive_init(70);
    at_cycle(81);
    check_levels("retry_wait", 1, 0, 0, 0, 1);
    drive_dh(83);
    drive_dv(86, 1'b1);

    // Hash exhaustion: three attempts, then hash timeout.
    push_exp(EV_SH, 91);
    push_exp(EV_SH, 100);
    push_exp(EV_SH, 109);
    push_exp(EV_RES, 118, 0, 1, 2);
    drive_init(90);
    at_cycle(119);
    check("exhaust_busy_after", int'(m_busy), 0);
    at_cycle(120);
    check_levels("exhaust_idle", 0, 0, 1, 0, 0);

    // Verify timeout.
    push_exp(EV_SH, 126);
    push_exp(EV_LH, 128);
    push_exp(EV_SV, 129);
    push_exp(EV_RES, 146, 0, 2, 0);
    sig_ok = 1'b1;
    drive_init(125);
    drive_dh(128);
    at_cycle(147);
    check_levels("vto_idle", 0, 0, 2, 0, 0);

    // done_verify on the timeout cycle wins.
    push_exp(EV_SH, 151);
    push_exp(EV_LH, 153);
    push_exp(EV_SV, 154);
    push_exp(EV_RES, 171, 1, 0, 0);
    drive_init(150);
    drive_dh(153);
    drive_dv(170, 1'b1);
    at_cycle(172);
    check_levels("vto_race_idle", 0, 0, 0, 1, 0);

    // Abort three cycles into WAIT_VERIFY.
    push_exp(EV_SH, 176);
    push_exp(EV_LH, 178);
    push_exp(EV_SV, 179);
    push_exp(EV_RES, 183, 0, 3, 0);
    drive_init(175);
    drive_dh(178);
    drive_abort(182);
    at_cycle(184);
    check_levels("abort_idle", 0, 0, 3, 0, 0);

    // Reset during WAIT_HASH: outputs clear, no result follows.
    push_exp(EV_SH, 191);
    drive_init(190);
    at_cycle(194);
    reset = 1'b1;
    at_cycle(195);
    check_levels("midop_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Stray pulses in IDLE are ignored.
    drive_dv(200, 1'b1);
    drive_dh(202);
    drive_abort(204);
    at_cycle(206);
    check_levels("stray_idle", 0, 0, 0, 0, 0);
    sel = 2'd2;

    // Queue disabled: a busy request is dropped with error 3.
    push_exp(EV_SH, 216);
    push_exp(EV_LH, 220);
    push_exp(EV_SV, 221);
    push_exp(EV_RES, 224, 0, 3, 0);
    drive_init(215);
    drive_init(218);
    check_levels("noq_drop", 1, 0, 3, 0, 0);
    drive_dh(220);
    drive_dv(223, 1'b1);
    at_cycle(232);
    check_levels("noq_idle", 0, 0, 3, 0, 0);

    check("missed_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
